// File: rtl/machine_trap_ctrl_pkg.sv
// Shared machine-mode CSR constants: trap FSM states, cause codes and CSR addresses.
package machine_trap_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_OPERATING   = 2'b00,
    ST_TRAP_TAKEN  = 2'b01,
    ST_TRAP_RETURN = 2'b10
  } trap_state_e;

  // Which pipeline value becomes mtval for the selected trap.
  typedef enum logic [1:0] {
    TVAL_ZERO  = 2'd0,
    TVAL_ADDR  = 2'd1,
    TVAL_INSTR = 2'd2
  } tval_src_e;

  localparam logic [3:0] CAUSE_IADDR_MISALIGNED = 4'd0;
  localparam logic [3:0] CAUSE_ILLEGAL_INSTR    = 4'd2;
  localparam logic [3:0] CAUSE_BREAKPOINT       = 4'd3;
  localparam logic [3:0] CAUSE_LADDR_MISALIGNED = 4'd4;
  localparam logic [3:0] CAUSE_SADDR_MISALIGNED = 4'd6;
  localparam logic [3:0] CAUSE_ECALL_M          = 4'd11;
  localparam logic [3:0] CAUSE_MSI              = 4'd3;
  localparam logic [3:0] CAUSE_MTI              = 4'd7;
  localparam logic [3:0] CAUSE_MEI              = 4'd11;

  localparam logic [11:0] CSR_MTVEC  = 12'h305;
  localparam logic [11:0] CSR_MEPC   = 12'h341;
  localparam logic [11:0] CSR_MCAUSE = 12'h342;
  localparam logic [11:0] CSR_MTVAL  = 12'h343;

endpackage

// File: rtl/trap_cause_encoder.sv
// Combinational trap selection: fixed exception priority, then gated interrupts, then MRET.
module trap_cause_encoder
  import machine_trap_ctrl_pkg::*;
(
  input  logic       iaddr_misaligned,
  input  logic       illegal_instr,
  input  logic       ecall,
  input  logic       ebreak,
  input  logic       laddr_misaligned,
  input  logic       saddr_misaligned,
  input  logic       mret,
  input  logic       meie,
  input  logic       mtie,
  input  logic       msie,
  input  logic       meip,
  input  logic       mtip,
  input  logic       msip,
  input  logic       mstatus_mie,
  output logic       trap,
  output logic       int_or_exc,
  output logic       mret_sel,
  output logic [3:0] cause,
  output logic [1:0] tval_src
);

  logic irq_ext;
  logic irq_sw;
  logic irq_tmr;

  assign irq_ext = meip & meie;
  assign irq_sw  = msip & msie;
  assign irq_tmr = mtip & mtie;

  always_comb begin
    trap       = 1'b0;
    int_or_exc = 1'b0;
    mret_sel   = 1'b0;
    cause      = 4'd0;
    tval_src   = TVAL_ZERO;
    if (iaddr_misaligned) begin
      trap     = 1'b1;
      cause    = CAUSE_IADDR_MISALIGNED;
      tval_src = TVAL_ADDR;
    end else if (illegal_instr) begin
      trap     = 1'b1;
      cause    = CAUSE_ILLEGAL_INSTR;
      tval_src = TVAL_INSTR;
    end else if (ecall) begin
      trap  = 1'b1;
      cause = CAUSE_ECALL_M;
    end else if (ebreak) begin
      trap  = 1'b1;
      cause = CAUSE_BREAKPOINT;
    end else if (laddr_misaligned) begin
      trap     = 1'b1;
      cause    = CAUSE_LADDR_MISALIGNED;
      tval_src = TVAL_ADDR;
    end else if (saddr_misaligned) begin
      trap     = 1'b1;
      cause    = CAUSE_SADDR_MISALIGNED;
      tval_src = TVAL_ADDR;
    end else if (mstatus_mie && (irq_ext || irq_sw || irq_tmr)) begin
      trap       = 1'b1;
      int_or_exc = 1'b1;
      cause      = irq_ext ? CAUSE_MEI : (irq_sw ? CAUSE_MSI : CAUSE_MTI);
    end else if (mret) begin
      mret_sel = 1'b1;
    end
  end

endmodule

// File: rtl/machine_trap_ctrl.sv
// Machine-mode trap controller: latches trap cause/epc/tval and sequences the
// one-cycle CSR-update and fetch-redirect strobes for trap entry and MRET.
module machine_trap_ctrl
  import machine_trap_ctrl_pkg::*;
#(
  parameter logic [1:0] RESET_STATE = 2'b00
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        stall_in,
  input  logic        illegal_instr_in,
  input  logic        ecall_in,
  input  logic        ebreak_in,
  input  logic        iaddr_misaligned_in,
  input  logic        laddr_misaligned_in,
  input  logic        saddr_misaligned_in,
  input  logic        mret_in,
  input  logic        meie_in,
  input  logic        mtie_in,
  input  logic        msie_in,
  input  logic        meip_in,
  input  logic        mtip_in,
  input  logic        msip_in,
  input  logic        mstatus_mie_in,
  input  logic [31:0] pc_in,
  input  logic [31:0] instr_in,
  input  logic [31:0] addr_in,
  input  logic [31:0] trap_address_in,
  input  logic [31:0] mepc_in,
  output logic        int_or_exc_out,
  output logic [3:0]  cause_out,
  output logic        set_cause_out,
  output logic        set_epc_out,
  output logic        set_tval_out,
  output logic [31:0] epc_out,
  output logic [31:0] tval_out,
  output logic        mie_clear_out,
  output logic        mie_set_out,
  output logic        flush_out,
  output logic        pc_load_out,
  output logic [31:0] next_pc_out
);

  trap_state_e state_reg, state_next;
  logic [3:0]  cause_reg, cause_next;
  logic        int_reg, int_next;
  logic [31:0] epc_reg, epc_next;
  logic [31:0] tval_reg, tval_next;

  logic        enc_trap;
  logic        enc_int;
  logic        enc_mret;
  logic [3:0]  enc_cause;
  logic [1:0]  enc_tval_src;
  logic [31:0] tval_sel;

  trap_cause_encoder u_encoder (
    .iaddr_misaligned (iaddr_misaligned_in),
    .illegal_instr    (illegal_instr_in),
    .ecall            (ecall_in),
    .ebreak           (ebreak_in),
    .laddr_misaligned (laddr_misaligned_in),
    .saddr_misaligned (saddr_misaligned_in),
    .mret             (mret_in),
    .meie             (meie_in),
    .mtie             (mtie_in),
    .msie             (msie_in),
    .meip             (meip_in),
    .mtip             (mtip_in),
    .msip             (msip_in),
    .mstatus_mie      (mstatus_mie_in),
    .trap             (enc_trap),
    .int_or_exc       (enc_int),
    .mret_sel         (enc_mret),
    .cause            (enc_cause),
    .tval_src         (enc_tval_src)
  );

  always_comb begin
    case (enc_tval_src)
      TVAL_ADDR:  tval_sel = addr_in;
      TVAL_INSTR: tval_sel = instr_in;
      default:    tval_sel = 32'd0;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_reg <= trap_state_e'(RESET_STATE);
      cause_reg <= 4'd0;
      int_reg   <= 1'b0;
      epc_reg   <= 32'd0;
      tval_reg  <= 32'd0;
    end else begin
      state_reg <= state_next;
      cause_reg <= cause_next;
      int_reg   <= int_next;
      epc_reg   <= epc_next;
      tval_reg  <= tval_next;
    end
  end

  // Strobes are also masked by reset so an aborted trap never reaches the CSRs.
  always_comb begin
    state_next    = state_reg;
    cause_next    = cause_reg;
    int_next      = int_reg;
    epc_next      = epc_reg;
    tval_next     = tval_reg;
    set_cause_out = 1'b0;
    set_epc_out   = 1'b0;
    set_tval_out  = 1'b0;
    mie_clear_out = 1'b0;
    mie_set_out   = 1'b0;
    flush_out     = 1'b0;
    pc_load_out   = 1'b0;
    next_pc_out   = 32'd0;
    case (state_reg)
      ST_OPERATING: begin
        if (!stall_in) begin
          if (enc_trap) begin
            state_next = ST_TRAP_TAKEN;
            cause_next = enc_cause;
            int_next   = enc_int;
            epc_next   = pc_in;
            tval_next  = tval_sel;
          end else if (enc_mret) begin
            state_next = ST_TRAP_RETURN;
          end
        end
      end
      ST_TRAP_TAKEN: begin
        next_pc_out = trap_address_in;
        if (!stall_in) begin
          state_next = ST_OPERATING;
          if (!rst_in) begin
            set_cause_out = 1'b1;
            set_epc_out   = 1'b1;
            set_tval_out  = 1'b1;
            mie_clear_out = 1'b1;
            flush_out     = 1'b1;
            pc_load_out   = 1'b1;
          end
        end
      end
      ST_TRAP_RETURN: begin
        next_pc_out = mepc_in & 32'hFFFF_FFFC;
        if (!stall_in) begin
          state_next = ST_OPERATING;
          if (!rst_in) begin
            mie_set_out = 1'b1;
            flush_out   = 1'b1;
            pc_load_out = 1'b1;
          end
        end
      end
      default: state_next = ST_OPERATING;
    endcase
  end

  assign cause_out      = cause_reg;
  assign int_or_exc_out = int_reg;
  assign epc_out        = epc_reg;
  assign tval_out       = tval_reg;

endmodule

// File: tb/tb_machine_trap_ctrl.sv
// Scoreboard bench for machine_trap_ctrl: directed scenarios plus random traffic,
// expected trap responses derived from the priority rules in a behavioural model.
module tb_machine_trap_ctrl;

  localparam logic [31:0] MTVEC_BASE = 32'h0000_1000;
  localparam logic [3:0]  EXC_CAUSE [6] = '{4'd0, 4'd2, 4'd11, 4'd3, 4'd4, 4'd6};

  typedef struct packed {
    logic        iam, ill, ecall, ebreak, lam, sam, mret;
    logic        meie, mtie, msie, meip, mtip, msip, gie;
    logic [31:0] pc, instr, addr, mepc;
  } stim_t;

  typedef struct packed {
    logic        ret;
    logic        intr;
    logic [3:0]  cause;
    logic [31:0] epc, tval, npc, cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst, stall;
  logic        ill, ecall, ebreak, iam, lam, sam, mret;
  logic        meie, mtie, msie, meip, mtip, msip, gie;
  logic [31:0] pc, instr, addr, trap_address, mepc;
  logic        int_or_exc;
  logic [3:0]  cause;
  logic        set_cause, set_epc, set_tval, mie_clear, mie_set, flush, pc_load;
  logic [31:0] epc, tval, next_pc;

  int          total = 0;
  int          bad = 0;
  logic [31:0] cyc = 32'd0;
  exp_t        sb[$];

  machine_trap_ctrl dut (
    .clk_in(clk), .rst_in(rst), .stall_in(stall),
    .illegal_instr_in(ill), .ecall_in(ecall), .ebreak_in(ebreak),
    .iaddr_misaligned_in(iam), .laddr_misaligned_in(lam), .saddr_misaligned_in(sam),
    .mret_in(mret), .meie_in(meie), .mtie_in(mtie), .msie_in(msie),
    .meip_in(meip), .mtip_in(mtip), .msip_in(msip), .mstatus_mie_in(gie),
    .pc_in(pc), .instr_in(instr), .addr_in(addr), .trap_address_in(trap_address),
    .mepc_in(mepc), .int_or_exc_out(int_or_exc), .cause_out(cause),
    .set_cause_out(set_cause), .set_epc_out(set_epc), .set_tval_out(set_tval),
    .epc_out(epc), .tval_out(tval), .mie_clear_out(mie_clear), .mie_set_out(mie_set),
    .flush_out(flush), .pc_load_out(pc_load), .next_pc_out(next_pc)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 32'd1;

  // Vectored mtvec: interrupts land at base + 4*cause, exceptions at base.
  assign trap_address = int_or_exc ? (MTVEC_BASE + {26'd0, cause, 2'b00}) : MTVEC_BASE;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply(input stim_t s);
    iam = s.iam; ill = s.ill; ecall = s.ecall; ebreak = s.ebreak;
    lam = s.lam; sam = s.sam; mret = s.mret;
    meie = s.meie; mtie = s.mtie; msie = s.msie;
    meip = s.meip; mtip = s.mtip; msip = s.msip; gie = s.gie;
    pc = s.pc; instr = s.instr; addr = s.addr; mepc = s.mepc;
  endtask

  // Reference: first raised exception in priority order, else an enabled
  // interrupt (MEI > MSI > MTI), else MRET.
  function automatic logic model(input stim_t s, output exp_t e);
    logic       fl[6];
    logic [3:0] c;
    logic       found;
    e = '0;
    found = 1'b0;
    fl[0] = s.iam; fl[1] = s.ill; fl[2] = s.ecall;
    fl[3] = s.ebreak; fl[4] = s.lam; fl[5] = s.sam;
    for (int i = 0; i < 6; i++) begin
      if (!found && fl[i]) begin
        found = 1'b1;
        c = EXC_CAUSE[i];
        e.cause = c;
        e.epc = s.pc;
        e.tval = (c == 4'd0 || c == 4'd4 || c == 4'd6) ? s.addr :
                 (c == 4'd2) ? s.instr : 32'd0;
        e.npc = MTVEC_BASE;
      end
    end
    if (!found && s.gie && ((s.meip && s.meie) || (s.msip && s.msie) || (s.mtip && s.mtie))) begin
      found = 1'b1;
      e.intr = 1'b1;
      e.cause = (s.meip && s.meie) ? 4'd11 : ((s.msip && s.msie) ? 4'd3 : 4'd7);
      e.epc = s.pc;
      e.npc = MTVEC_BASE + 32'(e.cause) * 32'd4;
    end
    if (!found && s.mret) begin
      found = 1'b1;
      e.ret = 1'b1;
      e.npc = {s.mepc[31:2], 2'b00};
    end
    return found;
  endfunction

  function automatic stim_t rand_stim();
    stim_t s;
    s.iam = ($urandom_range(0, 7) == 0); s.ill = ($urandom_range(0, 7) == 0);
    s.ecall = ($urandom_range(0, 7) == 0); s.ebreak = ($urandom_range(0, 7) == 0);
    s.lam = ($urandom_range(0, 7) == 0); s.sam = ($urandom_range(0, 7) == 0);
    s.mret = ($urandom_range(0, 3) == 0);
    s.meie = 1'($urandom); s.mtie = 1'($urandom); s.msie = 1'($urandom);
    s.meip = ($urandom_range(0, 3) == 0); s.mtip = ($urandom_range(0, 3) == 0);
    s.msip = ($urandom_range(0, 3) == 0); s.gie = 1'($urandom);
    s.pc = $urandom; s.instr = $urandom; s.addr = $urandom; s.mepc = $urandom;
    return s;
  endfunction

  // One transaction: optional stalled cycles with the event held, a detect
  // cycle, then (if a response is due) stalled/ignored-event response cycles.
  task automatic txn(input stim_t s, input int pre, input int post, input logic rst_resp);
    exp_t  e;
    logic  has;
    stim_t g;
    has = model(s, e);
    apply(s);
    stall = 1'b1;
    repeat (pre) tick();
    stall = 1'b0;
    e.cyc = cyc + 32'd1 + 32'(post);
    if (has && !rst_resp) sb.push_back(e);
    tick();
    if (has) begin
      g = rand_stim();
      g.mepc = s.mepc;
      apply(g);
      stall = 1'b1;
      repeat (post) tick();
      stall = 1'b0;
      rst = rst_resp;
      tick();
      rst = 1'b0;
    end
    apply('0);
  endtask

  // Monitor: pops an expectation whenever the DUT raises any strobe; when
  // nothing is pending, the latched trap values and idle outputs must hold.
  initial begin : monitor
    exp_t        e;
    logic [6:0]  strb;
    logic [3:0]  h_cause;
    logic        h_int;
    logic [31:0] h_epc, h_tval;
    h_cause = 4'd0; h_int = 1'b0; h_epc = 32'd0; h_tval = 32'd0;
    forever begin
      @(negedge clk);
      strb = {set_cause, set_epc, set_tval, mie_clear, mie_set, flush, pc_load};
      if (rst) begin
        chk("reset_strobes", 32'(strb), 32'd0);
        h_cause = 4'd0; h_int = 1'b0; h_epc = 32'd0; h_tval = 32'd0;
      end else if (strb != 7'd0) begin
        if (sb.size() == 0) begin
          chk("spurious_strobe", 32'(strb), 32'd0);
        end else begin
          e = sb.pop_front();
          chk("resp_cycle", cyc, e.cyc);
          chk("next_pc", next_pc, e.npc);
          if (e.ret) begin
            chk("ret_strobes", 32'(strb), 32'b0000111);
          end else begin
            chk("trap_strobes", 32'(strb), 32'b1111011);
            chk("cause", 32'(cause), 32'(e.cause));
            chk("int_or_exc", 32'(int_or_exc), 32'(e.intr));
            chk("epc", epc, e.epc);
            chk("tval", tval, e.tval);
            h_cause = e.cause; h_int = e.intr; h_epc = e.epc; h_tval = e.tval;
          end
          $display("txn cyc=%0d ret=%0d int=%0d cause=%0d epc=%h tval=%h npc=%h",
                   cyc, e.ret, e.intr, e.cause, e.epc, e.tval, e.npc);
        end
      end else if (sb.size() == 0 && !stall) begin
        chk("hold_cause", 32'(cause), 32'(h_cause));
        chk("hold_int", 32'(int_or_exc), 32'(h_int));
        chk("hold_epc", epc, h_epc);
        chk("hold_tval", tval, h_tval);
        chk("idle_next_pc", next_pc, 32'd0);
      end
    end
  end

  initial begin : driver
    stim_t s;
    rst = 1'b1; stall = 1'b0;
    apply('0);
    tick(); tick();
    rst = 1'b0;
    apply('0);
    tick();

    s = '0; s.ecall = 1'b1; s.pc = 32'h0000_0100;                    // ecall
    txn(s, 0, 0, 1'b0);
    s = '0; s.gie = 1'b1; s.mtie = 1'b1; s.mtip = 1'b1; s.pc = 32'h0000_0340;  // timer irq
    txn(s, 0, 0, 1'b0);
    s = '0; s.ill = 1'b1; s.instr = 32'hFFFF_FFFF; s.pc = 32'h0000_0400;
    s.gie = 1'b1; s.meie = 1'b1; s.meip = 1'b1;                        // exception beats irq
    txn(s, 0, 0, 1'b0);
    s.ill = 1'b0; s.pc = 32'h0000_0404;                                // irq still pending
    txn(s, 0, 0, 1'b0);
    s = '0; s.mret = 1'b1; s.mepc = 32'h0000_0204;                     // mret
    txn(s, 0, 0, 1'b0);
    s = '0; s.mret = 1'b1; s.mepc = 32'h0000_0307;                     // low mepc bits cleared
    txn(s, 0, 1, 1'b0);
    s = '0; s.ecall = 1'b1; s.pc = 32'h0000_0500;                      // stalled 3 cycles
    txn(s, 3, 0, 1'b0);
    s = '0; s.gie = 1'b1; s.msie = 1'b1; s.msip = 1'b1; s.mtie = 1'b1; s.mtip = 1'b1;
    s.pc = 32'h0000_0600;                                              // MSI beats MTI
    txn(s, 0, 2, 1'b0);
    s = '0; s.lam = 1'b1; s.sam = 1'b1; s.ebreak = 1'b1; s.addr = 32'hDEAD_BEE1;
    s.pc = 32'h0000_0700;                                              // ebreak beats lam/sam
    txn(s, 0, 0, 1'b0);
    s = '0; s.iam = 1'b1; s.ill = 1'b1; s.addr = 32'h0000_0802; s.pc = 32'h0000_0800;
    txn(s, 0, 0, 1'b0);
    s = '0; s.ecall = 1'b1; s.pc = 32'h0000_0900;                      // reset during TRAP_TAKEN
    txn(s, 0, 0, 1'b1);
    txn('0, 0, 0, 1'b0);

    for (int i = 0; i < 200; i++) begin
      txn(rand_stim(), ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0,
          ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0, 1'b0);
    end

    for (int i = 0; i < 20 && sb.size() != 0; i++) tick();
    tick(); tick();
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/machine_trap_ctrl.md
MACHINE_TRAP_CTRL -- requirements
Module: machine_trap_ctrl

Interface
REQ-001 SHALL have parameters: RESET_STATE, default 2'b00 (OPERATING), meaning the FSM state loaded on reset.
REQ-002 SHALL have ports, clock and reset first:
- clk_in, in, 1: clock; one clock domain.
- rst_in, in, 1: reset; synchronous, active-high.
- stall_in, in, 1: pipeline stall; holds the FSM and all registered outputs.
- illegal_instr_in, in, 1: illegal-instruction exception (cause 2).
- ecall_in, in, 1: environment call exception (cause 11).
- ebreak_in, in, 1: breakpoint exception (cause 3).
- iaddr_misaligned_in, in, 1: instruction address misaligned (cause 0).
- laddr_misaligned_in, in, 1: load address misaligned (cause 4).
- saddr_misaligned_in, in, 1: store address misaligned (cause 6).
- mret_in, in, 1: MRET instruction retiring.
- meie_in, mtie_in, msie_in, in, 1 each: mie enable bits.
- meip_in, mtip_in, msip_in, in, 1 each: mip pending bits.
- mstatus_mie_in, in, 1: global machine interrupt enable.
- pc_in, in, 32: PC of the instruction in the trap-check stage.
- instr_in, in, 32: that instruction word.
- addr_in, in, 32: offending data or branch address.
- trap_address_in, in, 32: vectored or direct trap target from the mtvec register.
- mepc_in, in, 32: current mepc.
- int_or_exc_out, out, 1: 1 = interrupt, 0 = exception. Drives the mtvec register.
- cause_out, out, 4: trap cause code. Drives the mtvec register.
- set_cause_out, set_epc_out, set_tval_out, out, 1 each: CSR write strobes.
- epc_out, out, 32: value written to mepc.
- tval_out, out, 32: value written to mtval.
- mie_clear_out, out, 1: MPIE <= MIE, MIE <= 0.
- mie_set_out, out, 1: MIE <= MPIE, MPIE <= 1.
- flush_out, out, 1: kill the instruction in the pipeline.
- pc_load_out, out, 1: redirect fetch.
- next_pc_out, out, 32: redirect target.

Function
REQ-003 The FSM SHALL have three states: OPERATING=00, TRAP_TAKEN=01, TRAP_RETURN=10. Encoding 11 SHALL return to OPERATING.
REQ-004 In OPERATING with stall_in=0, trap selection SHALL use this fixed priority, highest first:
- iaddr_misaligned
- illegal
- ecall
- ebreak
- laddr_misaligned
- saddr_misaligned
- interrupt
- mret
REQ-005 An interrupt SHALL be eligible only when mstatus_mie_in && (meip&meie | msip&msie | mtip&mtie).
REQ-006 Interrupt sub-priority SHALL be MEI (cause 11) > MSI (cause 3) > MTI (cause 7).
REQ-007 On a selected trap, the next edge SHALL enter TRAP_TAKEN and register:
- cause_out and int_or_exc_out.
- epc_out = pc_in, for exceptions and interrupts alike; an interrupt kills the current instruction.
- tval_out = addr_in for causes 0, 4 and 6; instr_in for cause 2; 0 otherwise.
REQ-008 In TRAP_TAKEN, the following SHALL be 1 for exactly one cycle: set_cause_out, set_epc_out, set_tval_out, mie_clear_out, flush_out, pc_load_out. next_pc_out SHALL equal trap_address_in. The FSM SHALL then return to OPERATING.
REQ-009 mret_in with no higher-priority event SHALL enter TRAP_RETURN. There, mie_set_out, flush_out and pc_load_out SHALL be 1 for one cycle, next_pc_out SHALL equal {mepc_in[31:2],2'b00}, and the FSM SHALL then return to OPERATING.
REQ-010 Trap-to-redirect latency SHALL be exactly one cycle after detection when stall_in=0.
REQ-011 Events arriving while in TRAP_TAKEN or TRAP_RETURN SHALL be ignored; the flushed instruction does not retire.
REQ-012 While stall_in=1, the state, cause_out, epc_out and tval_out SHALL hold, and all strobes SHALL be 0.
REQ-013 When an exception and an interrupt occur in the same cycle, the exception SHALL win; the interrupt stays pending and is re-evaluated afterwards.
REQ-014 cause_out and int_or_exc_out SHALL remain stable from TRAP_TAKEN entry until the next trap, so the mtvec register computes trap_address_in without a combinational loop.

Reset
REQ-015 On rst_in=1 at a clock edge, the state SHALL become OPERATING. All strobes, cause_out, int_or_exc_out, epc_out, tval_out and next_pc_out SHALL become 0.
REQ-016 A reset asserted in TRAP_TAKEN or TRAP_RETURN SHALL abort the sequence; no strobe fires in the following cycle.
REQ-017 Reset SHALL dominate stall_in.

Structure
REQ-018 State encodings, cause codes (0, 2, 3, 4, 6, 7, 11) and the MTVEC/MEPC/MCAUSE/MTVAL CSR addresses SHALL live in a shared CSR constants file.
REQ-019 Priority and cause encoding SHALL be a combinational sub-module, trap_cause_encoder. The FSM and registers SHALL stay in machine_trap_ctrl.

Verification
REQ-020 ecall_in=1 with pc_in=0x0000_0100 -> next cycle: cause_out=11, int_or_exc_out=0, epc_out=0x100, tval_out=0, all strobes 1 for one cycle, next_pc_out=trap_address_in.
REQ-021 mstatus_mie_in=1, mtie_in=1, mtip_in=1, with a vectored trap address from base 0x1000 -> cause_out=7, int_or_exc_out=1, next_pc_out=0x101C.
REQ-022 illegal_instr_in=1, instr_in=0xFFFF_FFFF, and meip&meie in the same cycle -> cause_out=2, tval_out=0xFFFF_FFFF; the interrupt is taken after return to OPERATING.
REQ-023 mret_in=1 with mepc_in=0x0000_0204 -> mie_set_out=1 for one cycle, next_pc_out=0x204, no cause or epc strobes.
REQ-024 Assert stall_in for 3 cycles with ecall_in=1 -> no strobes during the stall; the trap is taken one cycle after stall_in falls.
REQ-025 rst_in=1 during TRAP_TAKEN -> the next cycle shows OPERATING with all outputs 0.
